// File: rtl/n64_controller_rx.sv
// Joybus receiver: decodes N64 console frames (command, address, write payload) from the line.
// Optional macro N64_RX_GLITCH_FILTER_EN adds a 2-sample glitch filter after the synchronizer.
module n64_controller_rx #(
    parameter int unsigned LEVEL_WIDTH = 2
) (
    input  logic        sample_clk,
    input  logic        reset,
    input  logic        cur_operation,
    input  logic        data_rx,
    output logic [7:0]  cmd,
    output logic [15:0] addr,
    output logic        addr_valid,
    output logic [7:0]  data_byte,
    output logic        data_valid,
    output logic        tx_handoff,
    output logic        frame_error
);

    localparam logic [3:0] ZeroMin = 4'(2 * LEVEL_WIDTH);
    localparam logic [3:0] ZeroMax = 4'(4 * LEVEL_WIDTH);
    localparam logic [4:0] HighMax = 5'(8 * LEVEL_WIDTH);
    localparam logic [4:0] RunMax  = 5'(4 * LEVEL_WIDTH);

    typedef enum logic [1:0] {StIdle, StLowPhase, StHighPhase, StFrameEnd} state_e;

    logic sync1_q, sync2_q, line, line_prev_q, fall, rise;

    always_ff @(posedge sample_clk or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= data_rx;
            sync2_q <= sync1_q;
        end
    end

`ifdef N64_RX_GLITCH_FILTER_EN
    logic filt_q;

    // Accept a new level only once two consecutive synchronized samples agree.
    always_ff @(posedge sample_clk or posedge reset) begin
        if (reset) begin
            filt_q <= 1'b1;
        end else if (sync1_q == sync2_q) begin
            filt_q <= sync2_q;
        end
    end

    assign line = filt_q;
`else
    assign line = sync2_q;
`endif

    always_ff @(posedge sample_clk or posedge reset) begin
        if (reset) begin
            line_prev_q <= 1'b1;
        end else begin
            line_prev_q <= line;
        end
    end

    assign fall = line_prev_q & ~line;
    assign rise = ~line_prev_q & line;

    state_e      state_q, state_d;
    logic [3:0]  low_cnt_q, low_cnt_d;
    logic [4:0]  high_cnt_q, high_cnt_d;
    logic [8:0]  bit_cnt_q, bit_cnt_d;
    logic [8:0]  exp_len_q, exp_len_d;
    logic [15:0] shift_q, shift_d;
    logic [4:0]  hi_run_q, hi_run_d;
    logic        armed_q, armed_d;
    logic [7:0]  cmd_q, cmd_d;
    logic [15:0] addr_q, addr_d;
    logic [7:0]  data_byte_q, data_byte_d;
    logic        addr_valid_q, addr_valid_d;
    logic        data_valid_q, data_valid_d;
    logic        tx_q, tx_d;
    logic        frame_error_q, frame_error_d;

    logic        is_one, is_zero, err;
    logic [8:0]  new_bits;
    logic [15:0] new_shift;

    assign is_one  = low_cnt_q < ZeroMin;
    assign is_zero = (low_cnt_q >= ZeroMin) && (low_cnt_q <= ZeroMax);

    always_comb begin
        state_d       = state_q;
        low_cnt_d     = low_cnt_q;
        high_cnt_d    = high_cnt_q;
        bit_cnt_d     = bit_cnt_q;
        exp_len_d     = exp_len_q;
        shift_d       = shift_q;
        hi_run_d      = hi_run_q;
        armed_d       = armed_q;
        cmd_d         = cmd_q;
        addr_d        = addr_q;
        data_byte_d   = data_byte_q;
        tx_d          = tx_q;
        addr_valid_d  = 1'b0;
        data_valid_d  = 1'b0;
        frame_error_d = 1'b0;
        err           = 1'b0;
        new_bits      = bit_cnt_q + 9'd1;
        new_shift     = {shift_q[14:0], is_one};

        if (cur_operation) begin
            state_d    = StIdle;
            low_cnt_d  = 4'd0;
            high_cnt_d = 5'd0;
            bit_cnt_d  = 9'd0;
            hi_run_d   = 5'd0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    // After an error the line must idle high for a full bit before re-arming.
                    if (!armed_q) begin
                        if (!line) begin
                            hi_run_d = 5'd0;
                        end else if (hi_run_q >= RunMax - 5'd1) begin
                            armed_d = 1'b1;
                        end else begin
                            hi_run_d = hi_run_q + 5'd1;
                        end
                    end
                    if (fall && armed_q) begin
                        state_d    = StLowPhase;
                        low_cnt_d  = 4'd1;
                        high_cnt_d = 5'd0;
                        bit_cnt_d  = 9'd0;
                    end
                end
                StLowPhase: begin
                    if (rise) begin
                        if (bit_cnt_q >= 9'd8 && bit_cnt_q == exp_len_q) begin
                            if (is_one) begin
                                state_d = StFrameEnd;
                                tx_d    = ~tx_q;
                            end else begin
                                err = 1'b1;
                            end
                        end else if (is_one || is_zero) begin
                            state_d    = StHighPhase;
                            high_cnt_d = 5'd1;
                            shift_d    = new_shift;
                            bit_cnt_d  = new_bits;
                            if (new_bits == 9'd8) begin
                                cmd_d = new_shift[7:0];
                                unique case (new_shift[7:0])
                                    8'h02:   exp_len_d = 9'd24;
                                    8'h03:   exp_len_d = 9'd280;
                                    default: exp_len_d = 9'd8;
                                endcase
                            end
                            if (new_bits == 9'd24 && (cmd_q == 8'h02 || cmd_q == 8'h03)) begin
                                addr_d       = new_shift;
                                addr_valid_d = 1'b1;
                            end
                            if (cmd_q == 8'h03 && new_bits >= 9'd32 && new_bits[2:0] == 3'd0) begin
                                data_byte_d  = new_shift[7:0];
                                data_valid_d = 1'b1;
                            end
                        end else begin
                            err = 1'b1;
                        end
                    end else if (low_cnt_q != 4'hf) begin
                        low_cnt_d = low_cnt_q + 4'd1;
                    end
                end
                StHighPhase: begin
                    // Timeout wins over a coincident falling edge.
                    if (high_cnt_q > HighMax) begin
                        err = 1'b1;
                    end else if (fall) begin
                        state_d   = StLowPhase;
                        low_cnt_d = 4'd1;
                    end else if (high_cnt_q != 5'h1f) begin
                        high_cnt_d = high_cnt_q + 5'd1;
                    end
                end
                StFrameEnd: begin
                    state_d = StIdle;
                end
                default: state_d = StIdle;
            endcase

            if (err) begin
                state_d       = StIdle;
                frame_error_d = 1'b1;
                armed_d       = 1'b0;
                hi_run_d      = 5'd0;
                low_cnt_d     = 4'd0;
                high_cnt_d    = 5'd0;
                bit_cnt_d     = 9'd0;
            end
        end
    end

    always_ff @(posedge sample_clk or posedge reset) begin
        if (reset) begin
            state_q       <= StIdle;
            low_cnt_q     <= 4'd0;
            high_cnt_q    <= 5'd0;
            bit_cnt_q     <= 9'd0;
            exp_len_q     <= 9'd0;
            shift_q       <= 16'd0;
            hi_run_q      <= 5'd0;
            armed_q       <= 1'b1;
            cmd_q         <= 8'd0;
            addr_q        <= 16'd0;
            data_byte_q   <= 8'd0;
            addr_valid_q  <= 1'b0;
            data_valid_q  <= 1'b0;
            tx_q          <= 1'b0;
            frame_error_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            low_cnt_q     <= low_cnt_d;
            high_cnt_q    <= high_cnt_d;
            bit_cnt_q     <= bit_cnt_d;
            exp_len_q     <= exp_len_d;
            shift_q       <= shift_d;
            hi_run_q      <= hi_run_d;
            armed_q       <= armed_d;
            cmd_q         <= cmd_d;
            addr_q        <= addr_d;
            data_byte_q   <= data_byte_d;
            addr_valid_q  <= addr_valid_d;
            data_valid_q  <= data_valid_d;
            tx_q          <= tx_d;
            frame_error_q <= frame_error_d;
        end
    end

    assign cmd         = cmd_q;
    assign addr        = addr_q;
    assign addr_valid  = addr_valid_q;
    assign data_byte   = data_byte_q;
    assign data_valid  = data_valid_q;
    assign tx_handoff  = tx_q;
    assign frame_error = frame_error_q;

endmodule

// File: tb/tb_n64_controller_rx.sv
// Randomized self-checking bench for n64_controller_rx against a frame-level reference model.
module tb_n64_controller_rx;

    logic        clk = 1'b0;
    logic        rst;
    logic        cur_op;
    logic        data_rx;
    logic [7:0]  cmd;
    logic [15:0] addr;
    logic        addr_valid;
    logic [7:0]  data_byte;
    logic        data_valid;
    logic        tx_handoff;
    logic        frame_error;

    n64_controller_rx #(.LEVEL_WIDTH(2)) dut (
        .sample_clk    (clk),
        .reset         (rst),
        .cur_operation (cur_op),
        .data_rx       (data_rx),
        .cmd           (cmd),
        .addr          (addr),
        .addr_valid    (addr_valid),
        .data_byte     (data_byte),
        .data_valid    (data_valid),
        .tx_handoff    (tx_handoff),
        .frame_error   (frame_error)
    );

    always #5 clk = ~clk;

`ifdef N64_RX_GLITCH_FILTER_EN
    localparam int MinLen = 2;
    localparam int StopLat = 4;
`else
    localparam int MinLen = 1;
    localparam int StopLat = 3;
`endif

    int n_checks = 0;
    int n_fail = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Event monitor: samples just after each rising edge.
    int          av_cnt = 0;
    int          err_cnt = 0;
    int          tog_cnt = 0;
    logic [15:0] last_addr = 16'd0;
    logic [7:0]  dq[$];
    logic        tx_prev = 1'b0;

    always begin
        @(posedge clk);
        #1;
        if (rst) begin
            tx_prev = 1'b0;
        end else begin
            if (addr_valid) begin
                av_cnt++;
                last_addr = addr;
            end
            if (data_valid) dq.push_back(data_byte);
            if (frame_error) err_cnt++;
            if (tx_handoff !== tx_prev) tog_cnt++;
            tx_prev = tx_handoff;
        end
    end

    // Timing modes: 0 nominal, 1 random legal, 2 longest legal, 3 shortest legal.
    int         tmode = 0;
    logic [7:0] pay[32];

    function automatic int low_len(input bit b);
        case (tmode)
            1:       return b ? int'($urandom_range(MinLen, 3)) : int'($urandom_range(4, 8));
            2:       return b ? 3 : 8;
            3:       return b ? MinLen : 4;
            default: return b ? 2 : 6;
        endcase
    endfunction

    function automatic int high_len(input bit b);
        case (tmode)
            1:       return int'($urandom_range(MinLen, 16));
            2:       return 16;
            3:       return MinLen;
            default: return b ? 6 : 2;
        endcase
    endfunction

    task automatic drive(input logic v, input int n);
        data_rx = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input bit b);
        drive(1'b0, low_len(b));
        drive(1'b1, high_len(b));
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) send_bit(v[i]);
    endtask

    task automatic send_stop();
        drive(1'b0, low_len(1'b1));
        drive(1'b1, 30);
    endtask

    // Reference: frame length from command, address for 0x02/0x03, 32 payload bytes for 0x03.
    task automatic run_frame(input string tag, input logic [7:0] c, input logic [15:0] a);
        int  s_av, s_dv, s_err, s_tog, n_pay;
        bit  has_addr;
        s_av = av_cnt; s_dv = dq.size(); s_err = err_cnt; s_tog = tog_cnt;
        has_addr = (c == 8'h02) || (c == 8'h03);
        n_pay = (c == 8'h03) ? 32 : 0;
        send_byte(c);
        if (has_addr) begin
            send_byte(a[15:8]);
            send_byte(a[7:0]);
        end
        for (int i = 0; i < n_pay; i++) send_byte(pay[i]);
        send_stop();
        check_eq({tag, "_cmd"}, cmd, c);
        check_eq({tag, "_toggles"}, tog_cnt - s_tog, 1);
        check_eq({tag, "_errors"}, err_cnt - s_err, 0);
        check_eq({tag, "_addr_pulses"}, av_cnt - s_av, has_addr ? 1 : 0);
        if (has_addr) check_eq({tag, "_addr"}, last_addr, a);
        check_eq({tag, "_data_pulses"}, dq.size() - s_dv, n_pay);
        if (dq.size() - s_dv == n_pay) begin
            for (int i = 0; i < n_pay; i++) begin
                check_eq($sformatf("%s_pay%0d", tag, i), dq[s_dv + i], pay[i]);
            end
        end
    endtask

    // Malformed frame: nbits nominal bits, then a pulse of lo/hi cycles, a trailing low and idle.
    task automatic err_frame(input string tag, input int nbits, input int lo, input int hi);
        int s_err, s_tog;
        s_err = err_cnt; s_tog = tog_cnt;
        for (int i = 0; i < nbits; i++) send_bit(1'($urandom_range(0, 1)));
        drive(1'b0, lo);
        drive(1'b1, hi);
        drive(1'b0, 6);
        drive(1'b1, 30);
        check_eq({tag, "_errors"}, err_cnt - s_err, 1);
        check_eq({tag, "_toggles"}, tog_cnt - s_tog, 0);
        run_frame({tag, "_recover"}, 8'h00, 16'h0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_cmd"}, cmd, 0);
        check_eq({tag, "_addr"}, addr, 0);
        check_eq({tag, "_data_byte"}, data_byte, 0);
        check_eq({tag, "_addr_valid"}, addr_valid, 0);
        check_eq({tag, "_data_valid"}, data_valid, 0);
        check_eq({tag, "_frame_error"}, frame_error, 0);
        check_eq({tag, "_tx_handoff"}, tx_handoff, 0);
    endtask

    initial begin
        int         s_err, s_tog, s_av, k;
        logic [7:0] c;
        logic       tx_before;

        rst = 1'b1; cur_op = 1'b0; data_rx = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        drive(1'b1, 10);

        run_frame("cmd01", 8'h01, 16'h0);
        run_frame("cmd02", 8'h02, 16'h8001);
        for (int i = 0; i < 32; i++) pay[i] = 8'(i);
        run_frame("cmd03", 8'h03, 16'h0020);

        err_frame("low10", 3, 10, 2);
        err_frame("gap20", 4, 6, 20);
        err_frame("low9", 2, 9, 2);
        err_frame("high17", 5, 6, 17);

        // Stop bit with '0' length is malformed.
        s_err = err_cnt; s_tog = tog_cnt;
        send_byte(8'h01);
        drive(1'b0, 6);
        drive(1'b1, 30);
        check_eq("badstop_errors", err_cnt - s_err, 1);
        check_eq("badstop_toggles", tog_cnt - s_tog, 0);

        // Stop-bit rising edge to tx_handoff toggle latency.
        send_byte(8'h05);
        drive(1'b0, 2);
        tx_before = tx_handoff;
        data_rx = 1'b1;
        k = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #2;
            k++;
            if (tx_handoff !== tx_before) break;
        end
        check_eq("stop_latency", k, StopLat);
        @(negedge clk);
        drive(1'b1, 30);
        check_eq("lat_cmd", cmd, 8'h05);

        // Line ignored while the transmitter owns it.
        run_frame("pre_txown", 8'h00, 16'h0);
        s_err = err_cnt; s_tog = tog_cnt; s_av = av_cnt;
        cur_op = 1'b1;
        send_byte(8'h01);
        send_stop();
        check_eq("txown_cmd", cmd, 8'h00);
        check_eq("txown_toggles", tog_cnt - s_tog, 0);
        check_eq("txown_errors", err_cnt - s_err, 0);
        check_eq("txown_addr_pulses", av_cnt - s_av, 0);
        cur_op = 1'b0;
        drive(1'b1, 10);

        // One-cycle high glitch inside the low pulse of bit 7 of a 0x00 frame.
        s_err = err_cnt; s_tog = tog_cnt;
        for (int i = 0; i < 6; i++) send_bit(1'b0);
        drive(1'b0, 2);
        drive(1'b1, 1);
        drive(1'b0, 3);
        drive(1'b1, 2);
        send_bit(1'b0);
        send_stop();
`ifdef N64_RX_GLITCH_FILTER_EN
        check_eq("glitch_cmd", cmd, 8'h00);
        check_eq("glitch_toggles", tog_cnt - s_tog, 1);
        check_eq("glitch_errors", err_cnt - s_err, 0);
`else
        check_eq("glitch_toggles", tog_cnt - s_tog, 0);
        check_eq("glitch_errors", err_cnt - s_err, 1);
`endif
        drive(1'b1, 20);

        tmode = 2;
        run_frame("longest", 8'h02, 16'h5aa5);
        tmode = 3;
        run_frame("shortest", 8'h02, 16'ha55a);

        tmode = 1;
        for (int f = 0; f < 10; f++) begin
            case ($urandom_range(0, 3))
                0:       c = 8'h02;
                1:       c = 8'h03;
                default: c = 8'($urandom_range(0, 255));
            endcase
            for (int i = 0; i < 32; i++) pay[i] = 8'($urandom_range(0, 255));
            run_frame($sformatf("rand%0d", f), c, 16'($urandom_range(0, 65535)));
        end
        tmode = 0;

        // Reset in the middle of a 0x02 frame, at address bit 12.
        s_err = err_cnt;
        send_byte(8'h02);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_outputs("midreset");
        rst = 1'b0;
        drive(1'b1, 30);
        check_eq("midreset_errors", err_cnt - s_err, 0);
        run_frame("post_reset", 8'h02, 16'h1234);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/n64_controller_rx.md
N64_CONTROLLER_RX -- requirements
Module: n64_controller_rx

Interface
REQ-001 SHALL have parameter LEVEL_WIDTH, default 2: sample_clk cycles per Joybus level; a bit is 4 levels, so BIT_WIDTH = 4*LEVEL_WIDTH.
REQ-002 SHALL have port sample_clk, input, 1: the only clock; all logic on posedge.
REQ-003 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-004 SHALL have port cur_operation, input, 1: 0 = Rx owns the line, 1 = Tx owns it.
REQ-005 SHALL have port data_rx, input, 1: raw open-drain Joybus line, asynchronous to sample_clk.
REQ-006 SHALL have port cmd, output, 8: last received command byte.
REQ-007 SHALL have port addr, output, 16: address bytes of a READ (0x02) or WRITE (0x03) command.
REQ-008 SHALL have port addr_valid, output, 1: one-cycle pulse when addr updates.
REQ-009 SHALL have port data_byte, output, 8: WRITE payload byte.
REQ-010 SHALL have port data_valid, output, 1: one-cycle pulse per payload byte.
REQ-011 SHALL have port tx_handoff, output, 1: toggles once per good frame, passing the line to the transmitter.
REQ-012 SHALL have port frame_error, output, 1: one-cycle pulse on a malformed frame.

Function
REQ-013 SHALL pass data_rx through a 2-flop synchronizer, and all decoding SHALL use the synchronized value.
REQ-014 SHALL implement states IDLE, LOW_PHASE, HIGH_PHASE and FRAME_END.
REQ-015 While cur_operation=1, the block SHALL force IDLE, clear all counters, and ignore the line.
REQ-016 IDLE->LOW_PHASE SHALL occur on a synchronized falling edge, with low_cnt loaded to 1 and bit_cnt cleared.
REQ-017 In LOW_PHASE, low_cnt (4-bit, saturating at 15) SHALL increment each cycle the line stays low.
REQ-018 On a rising edge, the block SHALL classify the low pulse: low_cnt < 2*LEVEL_WIDTH -> '1'; 2*LEVEL_WIDTH <= low_cnt <= 4*LEVEL_WIDTH -> '0'; otherwise error; a valid bit SHALL lead to HIGH_PHASE.
REQ-019 Decoded bits SHALL shift MSB first into a shift register, and bit_cnt (9-bit) SHALL increment once per decoded bit.
REQ-020 In HIGH_PHASE, high_cnt (5-bit, saturating) SHALL count high cycles; a falling edge SHALL lead to LOW_PHASE; high_cnt > 2*BIT_WIDTH SHALL cause an error.
REQ-021 Expected frame length SHALL be set when bit_cnt reaches 8: cmd 0x02 -> 24 bits; 0x03 -> 280 bits; all other values -> 8 bits.
REQ-022 cmd SHALL update at bit_cnt=8.
REQ-023 addr SHALL update and addr_valid SHALL pulse at bit_cnt=24 for commands 0x02/0x03.
REQ-024 For 0x03, data_byte SHALL update and data_valid SHALL pulse at bit_cnt=32,40,...,280, giving 32 pulses.
REQ-025 After the expected length, the next low pulse is the stop bit: '1'-length -> FRAME_END; any other length -> error.
REQ-026 FRAME_END SHALL last one cycle, toggle tx_handoff, and return to IDLE.
REQ-027 On any error, the block SHALL pulse frame_error, leave tx_handoff unchanged, and go to IDLE; it SHALL then wait for the line to be high for BIT_WIDTH consecutive cycles before accepting a new falling edge.
REQ-028 If a falling edge occurs on the same cycle as a timeout, the error SHALL take priority.
REQ-029 Latency SHALL be: a line edge reaches the decoder 2 cycles later (3 with filter); the stop-bit rising edge reaches the tx_handoff toggle 3 cycles later (4 with filter).

Reset
REQ-030 While reset is asserted, cmd=0, addr=0, data_byte=0, addr_valid=0, data_valid=0, frame_error=0, tx_handoff=0.
REQ-031 While reset is asserted, the synchronizer flops=1, state=IDLE, all counters=0.
REQ-032 Reset asserted mid-frame SHALL abort the frame without any error pulse.

Configuration
REQ-033 With macro N64_RX_GLITCH_FILTER_EN defined, a line level change SHALL be accepted only after 2 consecutive equal synchronized samples; this adds 1 cycle of latency and makes 1-cycle glitches invisible.
REQ-034 Without N64_RX_GLITCH_FILTER_EN, the synchronized value SHALL be used directly.

Verification (LEVEL_WIDTH=2, filter off)
REQ-035 Command 0x01 (bit '0' = 6 low/2 high cycles, bit '1' = 2 low/6 high), then stop bit -> cmd=0x01, tx_handoff toggles exactly once, no frame_error.
REQ-036 Command 0x02 with addr 0x8001, then stop -> addr=0x8001, one addr_valid pulse, no data_valid, tx_handoff toggles.
REQ-037 Command 0x03 with addr 0x0020 and payload bytes 0x00..0x1F, then stop -> 32 data_valid pulses in order 0x00..0x1F, then tx_handoff toggles.
REQ-038 A 10-cycle low pulse mid-byte, and separately a 20-cycle high gap after bit 5 -> frame_error pulses once, tx_handoff unchanged, and the next good 0x00 frame decodes correctly.
REQ-039 cur_operation=1 during a full 0x01 frame -> no output changes; reset asserted at bit 12 of a 0x02 frame -> all outputs equal their reset values and no frame_error.
REQ-040 Filter on, with a 1-cycle high glitch inside a '0' low pulse -> bit still decodes as '0'; filter off, same stimulus -> frame_error.
